// File: rtl/fmadd_normalizer.sv
// -----------------------------------------------------------------------------
// fmadd_normalizer
//
// Post-addition normalizer for the fused multiply-add datapath. Takes the raw
// sum from the addition lane together with its alignment rounding bits and
// normalizes it so that the leading one sits in the hidden-bit position. A
// carry-out is handled with a single right shift. A sum below the hidden-bit
// position is shifted left one bit per cycle, and the exponent is adjusted as
// it goes. The output is a mantissa with its hidden bit, plus guard, round and
// sticky bits, ready for a rounding stage.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   in_valid      operand valid (only looked at in IDLE)
//   in_ready      block can accept an operand (high in IDLE)
//   in_sign       sign of the addition-lane result
//   in_exp        biased exponent from exponent matching (exp+2 bits)
//   in_mantissa   raw sum (2*man+5 bits); MSB = carry-out, MSB-1 = leading one
//   in_guard/round/sticky  rounding bits from alignment
//   out_valid     result valid (high in DONE)
//   out_ready     downstream accepts the result
//   out_sign/exp/mantissa  normalized result (mantissa includes hidden bit)
//   out_guard/round/sticky rounding bits for the rounder
//   out_zero      result is an exact zero
//   out_underflow left shift stopped at the minimum exponent
//   out_overflow  final exponent has reached the all-ones/overflow range
// -----------------------------------------------------------------------------
module fmadd_normalizer #(
  parameter int man = 22,
  parameter int exp = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [exp+1:0]   in_exp,
  input  logic [2*man+4:0] in_mantissa,
  input  logic             in_guard,
  input  logic             in_round,
  input  logic             in_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [exp+1:0]   out_exp,
  output logic [man:0]     out_mantissa,
  output logic             out_guard,
  output logic             out_round,
  output logic             out_sticky,
  output logic             out_zero,
  output logic             out_underflow,
  output logic             out_overflow
);

  localparam int WW = 2*man+7;   // working register: {sum, guard, round}
  localparam int EW = exp+2;     // exponent width, with headroom for overflow

  localparam logic [EW-1:0] E_ONE = EW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    r_state;
  logic [WW-1:0] r_w;
  logic          r_s;
  logic [EW-1:0] r_e;
  logic          r_sign;
  logic          r_zero;
  logic          r_unf;

  // W[WW-1] is the carry-out position and W[WW-2] is the hidden-bit position.
  logic w_carry;
  logic w_lead;
  logic w_empty;

  assign w_carry = r_w[WW-1];
  assign w_lead  = r_w[WW-2];
  assign w_empty = (r_w == '0) && !r_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_w     <= '0;
      r_s     <= 1'b0;
      r_e     <= '0;
      r_sign  <= 1'b0;
      r_zero  <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_w     <= {in_mantissa, in_guard, in_round};
            r_s     <= in_sticky;
            r_e     <= in_exp;
            r_sign  <= in_sign;
            r_zero  <= 1'b0;
            r_unf   <= 1'b0;
            r_state <= NORM;
          end
        end
        NORM: begin
          // The checks are in priority order. Exact zero wins over everything.
          // A carry needs exactly one right shift. A value already normalized
          // stops here. The exponent floor stops the left shift before E can
          // drop below 1.
          if (w_empty) begin
            r_e     <= '0;
            r_zero  <= 1'b1;
            r_state <= DONE;
          end else if (w_carry) begin
            r_w     <= {1'b0, r_w[WW-1:1]};
            r_s     <= r_s | r_w[0];
            r_e     <= r_e + E_ONE;
            r_state <= DONE;
          end else if (w_lead) begin
            r_state <= DONE;
          end else if (r_e <= E_ONE) begin
            r_unf   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_w <= {r_w[WW-2:0], 1'b0};
            r_e <= r_e - E_ONE;
          end
        end
        DONE: begin
          // The state returns to IDLE on the handshake. Any new operand is
          // taken on a later edge, never in this same cycle.
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  // Every output comes straight from state. They stay frozen in DONE while
  // the downstream stalls.
  assign out_sign      = r_sign;
  assign out_exp       = r_e;
  assign out_mantissa  = r_w[2*man+5:man+5];
  assign out_guard     = r_w[man+4];
  assign out_round     = r_w[man+3];
  assign out_sticky    = (|r_w[man+2:0]) | r_s;
  assign out_zero      = r_zero;
  assign out_underflow = r_unf;
  assign out_overflow  = r_e[exp+1] | (&r_e[exp:0]);

endmodule

// File: doc/fmadd_normalizer.md
FMADD_NORMALIZER -- requirements
Module: fmadd_normalizer

Interface
REQ-001 SHALL have parameter man, default 22: mantissa field MSB index.
REQ-002 SHALL have parameter exp, default 7: exponent field MSB index.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  input operand valid.
REQ-007 SHALL have port in_ready  output  1  block can accept an operand.
REQ-008 SHALL have port in_sign  input  1  sign of the addition-lane result.
REQ-009 SHALL have port in_exp  input  exp+2  biased exponent from exponent matching.
REQ-010 SHALL have port in_mantissa  input  2*man+5  raw sum; bit 2*man+4 = carry-out, bit 2*man+3 = normalized leading-one position.
REQ-011 SHALL have ports in_guard, in_round, in_sticky  input  1 each  rounding bits from alignment.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have ports out_sign  output  1, out_exp  output  exp+2, out_mantissa  output  man+1 (hidden bit included).
REQ-015 SHALL have ports out_guard, out_round, out_sticky, out_zero, out_underflow, out_overflow  output  1 each.

Function
REQ-016 SHALL hold a working register W of 2*man+7 bits = {in_mantissa, in_guard, in_round}, a sticky register S, an exponent register E and a sign register.
REQ-017 SHALL implement states IDLE, NORM, DONE.
REQ-018 IDLE: in_ready=1; on in_valid, load W, S=in_sticky, E=in_exp, sign, and go to NORM.
REQ-019 NORM, priority order per cycle: (a) W==0 and S==0 -> E=0, zero flag, go to DONE; (b) W[2*man+6]=1 -> W>>1, S|=W[0], E+1, go to DONE; (c) W[2*man+5]=1 -> go to DONE; (d) E<=1 -> underflow flag, go to DONE; (e) otherwise W<<1 with 0 inserted, E-1, stay in NORM.
REQ-020 Time in NORM SHALL be k+1 cycles, where k is the left-shift count. Cases (a), (b) and (c) on first entry take 1 cycle.
REQ-021 DONE: out_valid=1 and in_ready=0. On out_ready=1, return to IDLE next cycle. A new operand SHALL NOT be accepted in the same cycle.
REQ-022 Outputs SHALL be driven from registers as follows:
- out_mantissa = W[2*man+5:man+5]
- out_guard = W[man+4]
- out_round = W[man+3]
- out_sticky = |W[man+2:0] | S
REQ-023 out_overflow SHALL be E[exp+1] | &E[exp:0], evaluated on the final E.
REQ-024 out_zero and out_underflow SHALL be the flags captured in NORM, cleared on the next load.
REQ-025 All outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 in_valid SHALL be ignored outside IDLE.
REQ-027 Exponent arithmetic SHALL be exp+2 bits unsigned. The E<=1 guard SHALL prevent decrement below 1.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL take these values next cycle:
- state = IDLE, in_ready=1, out_valid=0
- W, S, E, sign and all flags = 0, so every data output = 0
REQ-029 Reset SHALL take priority over any handshake. A reset in NORM or DONE SHALL discard the in-flight operand.

Verification
REQ-030 Normalized input: in_mantissa bit 47 set only, in_exp=127, g=r=s=0 -> 1 NORM cycle; out_exp=127, out_mantissa=23'h400000, G/R/S=0.
REQ-031 Carry input: in_mantissa=49'h1_0000_0000_0001, in_exp=127, g=0, r=1 -> out_exp=128, out_mantissa=23'h400000, out_sticky=1.
REQ-032 Left shift by 3: in_mantissa bit 44 set only, in_exp=10 -> 4 NORM cycles; out_exp=7, out_mantissa=23'h400000.
REQ-033 Underflow and zero:
- in_mantissa bit 40 set, in_exp=3 -> out_exp=1, out_underflow=1.
- all-zero input with g=r=s=0 -> out_zero=1, out_exp=0.
REQ-034 Overflow: carry input with in_exp=254 -> out_exp=255, out_overflow=1.
REQ-035 Backpressure and reset:
- out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
- rst pulsed mid-NORM -> next cycle IDLE, out_valid=0, in_ready=1, no result emitted.
